tlk2711_tx_sched: RTL and testbench

Transmit-side frame scheduler for the TLK2711 path. It takes the TX configuration registers (base address, body/tail length, body count, mode) on the config-done strobe. It then sequences one DDR read command per outgoing frame to the TX DMA/link, with bounded outstanding frames, and raises the TX-complete interrupt when the whole packet has been sent. It sits between the register block and the TX DMA reader.

---
 rtl/tlk2711_tx_sched.sv | 133 +++++++++++++
 tb/tb_tlk2711_tx_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_sched.sv
// TLK2711 transmit frame scheduler: latches the TX packet config, issues one DDR read
// command per frame with bounded outstanding frames, and signals completion or abort.
module tlk2711_tx_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_OUT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_soft_rst,
    input  logic                  i_tx_config_done,
    input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
    input  logic [15:0]           i_tx_packet_body,
    input  logic [15:0]           i_tx_packet_tail,
    input  logic [15:0]           i_tx_body_num,
    input  logic [3:0]            i_tx_mode,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [15:0]           o_cmd_len,
    output logic                  o_cmd_last,
    input  logic                  i_frame_done,
    input  logic                  i_link_loss,
    output logic                  o_tx_interrupt,
    output logic                  o_abort,
    output logic                  o_busy,
    output logic [15:0]           o_frame_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE, S_ABORT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] base;
        logic [15:0]           body;
        logic [15:0]           tail;
        logic [15:0]           num;
    } cfg_t;

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    state_t      state, state_nx;
    cfg_t        cfg;
    logic [15:0] nb;
    logic [16:0] total, issued, issued_nx;
    logic [3:0]  outstd, outstd_nx;
    logic        take, xfer, fdone;

    always_comb begin
        take  = (state == S_IDLE) && i_tx_config_done && (i_tx_mode == 4'd0);
        nb    = (cfg.body == 16'd0) ? 16'd0 : cfg.num;
        total = {1'b0, nb} + 17'(cfg.tail != 16'd0);
        xfer  = o_cmd_valid & i_cmd_ready;
        // frame completions only count against commands of the active packet
        fdone = i_frame_done && (outstd != 4'd0) && (state == S_ISSUE || state == S_DRAIN);

        issued_nx = issued + 17'(xfer);
        outstd_nx = outstd;
        if (xfer && !fdone)
            outstd_nx = outstd + 4'd1;
        else if (fdone && !xfer)
            outstd_nx = outstd - 4'd1;
        if (state == S_LOAD) begin
            issued_nx = '0;
            outstd_nx = '0;
        end

        state_nx = state;
        case (state)
            S_IDLE:  if (take) state_nx = S_LOAD;
            S_LOAD:  if (i_link_loss) state_nx = S_ABORT;
                     else if (total == 17'd0) state_nx = S_DONE;
                     else state_nx = S_ISSUE;
            S_ISSUE: if (i_link_loss) state_nx = S_ABORT;
                     else if (issued_nx == total) state_nx = S_DRAIN;
            S_DRAIN: if (i_link_loss) state_nx = S_ABORT;
                     else if (outstd_nx == 4'd0) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cfg            <= '0;
            issued         <= '0;
            outstd         <= '0;
            o_cmd_valid    <= 1'b0;
            o_cmd_addr     <= '0;
            o_cmd_len      <= '0;
            o_cmd_last     <= 1'b0;
            o_tx_interrupt <= 1'b0;
            o_abort        <= 1'b0;
            o_busy         <= 1'b0;
            o_frame_cnt    <= '0;
        end else if (i_soft_rst) begin
            state          <= S_IDLE;
            cfg            <= '0;
            issued         <= '0;
            outstd         <= '0;
            o_cmd_valid    <= 1'b0;
            o_cmd_addr     <= '0;
            o_cmd_len      <= '0;
            o_cmd_last     <= 1'b0;
            o_tx_interrupt <= 1'b0;
            o_abort        <= 1'b0;
            o_busy         <= 1'b0;
            o_frame_cnt    <= '0;
        end else begin
            state  <= state_nx;
            issued <= issued_nx;
            outstd <= outstd_nx;
            if (take)
                cfg <= '{base: i_tx_base_addr, body: i_tx_packet_body,
                         tail: i_tx_packet_tail, num: i_tx_body_num};

            // command fields describe the next command to issue; they only move on a transfer
            if (state == S_LOAD)
                o_cmd_addr <= cfg.base;
            else if (xfer)
                o_cmd_addr <= o_cmd_addr + ADDR_WIDTH'(o_cmd_len);
            o_cmd_len   <= (issued_nx < {1'b0, nb}) ? cfg.body : cfg.tail;
            o_cmd_last  <= (issued_nx == total - 17'd1);
            o_cmd_valid <= (state_nx == S_ISSUE) && (outstd_nx < MAX_OUT_C);

            if (state == S_LOAD)
                o_frame_cnt <= '0;
            else if (fdone && o_frame_cnt != 16'hFFFF)
                o_frame_cnt <= o_frame_cnt + 16'd1;

            o_tx_interrupt <= (state_nx == S_DONE);
            o_abort        <= (state_nx == S_ABORT);
            o_busy         <= (state_nx == S_LOAD) || (state_nx == S_ISSUE) || (state_nx == S_DRAIN);
        end
    end
endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// Directed bench for tlk2711_tx_sched: drives inputs and samples outputs on the falling
// edge, logs every command handshake and compares against hand-computed values.
module tb_tlk2711_tx_sched;
    localparam int AW = 32;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_soft_rst = 1'b0;
    logic          i_tx_config_done = 1'b0;
    logic [AW-1:0] i_tx_base_addr = '0;
    logic [15:0]   i_tx_packet_body = '0;
    logic [15:0]   i_tx_packet_tail = '0;
    logic [15:0]   i_tx_body_num = '0;
    logic [3:0]    i_tx_mode = '0;
    logic          i_cmd_ready = 1'b0;
    logic          i_frame_done = 1'b0;
    logic          i_link_loss = 1'b0;
    logic          o_cmd_valid, o_cmd_last, o_tx_interrupt, o_abort, o_busy;
    logic [AW-1:0] o_cmd_addr;
    logic [15:0]   o_cmd_len, o_frame_cnt;

    always #5 clk = ~clk;

    tlk2711_tx_sched #(.ADDR_WIDTH(AW), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst),
        .i_tx_config_done(i_tx_config_done), .i_tx_base_addr(i_tx_base_addr),
        .i_tx_packet_body(i_tx_packet_body), .i_tx_packet_tail(i_tx_packet_tail),
        .i_tx_body_num(i_tx_body_num), .i_tx_mode(i_tx_mode),
        .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_addr(o_cmd_addr),
        .o_cmd_len(o_cmd_len), .o_cmd_last(o_cmd_last), .i_frame_done(i_frame_done),
        .i_link_loss(i_link_loss), .o_tx_interrupt(o_tx_interrupt), .o_abort(o_abort),
        .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    int irq_cnt = 0, abort_cnt = 0, fd_delay = 0, stall = 0;
    int fd_q[$];
    logic [AW-1:0] hs_addr[$];
    logic [15:0]   hs_len[$];
    logic          hs_last[$];
    bit            ready_en = 1'b1, held = 1'b0;
    logic [AW-1:0] h_addr;
    logic [15:0]   h_len;
    logic          h_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one cycle: observe outputs at the falling edge, then set inputs for the next rising edge
    task automatic step();
        @(negedge clk);
        i_tx_config_done = 1'b0;
        if (o_tx_interrupt) irq_cnt++;
        if (o_abort) abort_cnt++;
        if (held && o_cmd_valid) begin
            check("hold_addr", 64'(o_cmd_addr), 64'(h_addr));
            check("hold_len", 64'(o_cmd_len), 64'(h_len));
            check("hold_last", 64'(o_cmd_last), 64'(h_last));
        end
        i_frame_done = 1'b0;
        if (fd_q.size() > 0 && fd_q[0] == cyc) begin
            i_frame_done = 1'b1;
            void'(fd_q.pop_front());
        end
        held = 1'b0;
        if (o_cmd_valid && stall > 0) begin
            i_cmd_ready = 1'b0;
            stall--;
            held   = 1'b1;
            h_addr = o_cmd_addr;
            h_len  = o_cmd_len;
            h_last = o_cmd_last;
        end else begin
            i_cmd_ready = ready_en;
        end
        if (o_cmd_valid && i_cmd_ready) begin
            hs_addr.push_back(o_cmd_addr);
            hs_len.push_back(o_cmd_len);
            hs_last.push_back(o_cmd_last);
            if (fd_delay > 0) fd_q.push_back(cyc + fd_delay);
        end
        cyc++;
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [15:0] body, input logic [15:0] tail,
                         input logic [15:0] num, input logic [3:0] mode);
        step();
        hs_addr.delete();
        hs_len.delete();
        hs_last.delete();
        fd_q.delete();
        irq_cnt   = 0;
        abort_cnt = 0;
        i_tx_base_addr   = base;
        i_tx_packet_body = body;
        i_tx_packet_tail = tail;
        i_tx_body_num    = num;
        i_tx_mode        = mode;
        i_tx_config_done = 1'b1;
    endtask

    task automatic run_until_end(input int max, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            if (o_tx_interrupt || o_abort) seen = 1'b1;
        end
        check({tag, "_timeout"}, 64'(seen), 64'd1);
    endtask

    logic [AW-1:0] exp_addr[4];
    logic [15:0]   exp_len[4];
    logic          exp_last[4];

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(o_cmd_valid), 64'd0);
        check("rst_addr", 64'(o_cmd_addr), 64'd0);
        check("rst_len", 64'(o_cmd_len), 64'd0);
        check("rst_last", 64'(o_cmd_last), 64'd0);
        check("rst_irq", 64'(o_tx_interrupt), 64'd0);
        check("rst_abort", 64'(o_abort), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_fcnt", 64'(o_frame_cnt), 64'd0);
        rst = 1'b0;
        repeat (2) step();

        // non-zero mode: strobe ignored
        start(32'h1000_0000, 16'd870, 16'd100, 16'd3, 4'd1);
        step();
        check("mode_busy0", 64'(o_busy), 64'd0);
        step();
        check("mode_busy1", 64'(o_busy), 64'd0);
        check("mode_valid", 64'(o_cmd_valid), 64'd0);

        // empty packet: interrupt two cycles after the strobe, no command
        start(32'h1000_0000, 16'd870, 16'd0, 16'd0, 4'd0);
        step();
        check("deg_load_busy", 64'(o_busy), 64'd1);
        check("deg_irq_early", 64'(o_tx_interrupt), 64'd0);
        step();
        check("deg_irq", 64'(o_tx_interrupt), 64'd1);
        check("deg_busy", 64'(o_busy), 64'd0);
        repeat (3) step();
        check("deg_irq_cnt", 64'(irq_cnt), 64'd1);
        check("deg_no_cmd", 64'(hs_addr.size()), 64'd0);

        // basic packet: 3 bodies + tail
        fd_delay = 5;
        start(32'h1000_0000, 16'd870, 16'd100, 16'd3, 4'd0);
        step();
        check("basic_load_busy", 64'(o_busy), 64'd1);
        check("basic_load_valid", 64'(o_cmd_valid), 64'd0);
        step();
        check("basic_first_valid", 64'(o_cmd_valid), 64'd1);
        run_until_end(200, "basic");
        check("basic_busy_fall", 64'(o_busy), 64'd0);
        repeat (5) step();
        exp_addr = '{32'h1000_0000, 32'h1000_0366, 32'h1000_06CC, 32'h1000_0A32};
        exp_len  = '{16'd870, 16'd870, 16'd870, 16'd100};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        check("basic_ncmd", 64'(hs_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_addr.size()) begin
                check($sformatf("basic_addr%0d", i), 64'(hs_addr[i]), 64'(exp_addr[i]));
                check($sformatf("basic_len%0d", i), 64'(hs_len[i]), 64'(exp_len[i]));
                check($sformatf("basic_last%0d", i), 64'(hs_last[i]), 64'(exp_last[i]));
            end
        end
        check("basic_irq_cnt", 64'(irq_cnt), 64'd1);
        check("basic_fcnt", 64'(o_frame_cnt), 64'd4);

        // link loss after two handshakes; first frame completes alongside the second handshake
        fd_delay = 1;
        start(32'h2000_0000, 16'd870, 16'd100, 16'd3, 4'd0);
        for (int i = 0; i < 20 && hs_addr.size() < 2; i++) step();
        check("abort_hs2", 64'(hs_addr.size()), 64'd2);
        i_link_loss = 1'b1;
        step();
        check("abort_valid_drop", 64'(o_cmd_valid), 64'd0);
        check("abort_pulse", 64'(o_abort), 64'd1);
        check("abort_busy", 64'(o_busy), 64'd0);
        i_link_loss = 1'b0;
        repeat (5) step();
        check("abort_cnt", 64'(abort_cnt), 64'd1);
        check("abort_no_irq", 64'(irq_cnt), 64'd0);
        check("abort_fcnt", 64'(o_frame_cnt), 64'd1);
        check("abort_ncmd", 64'(hs_addr.size()), 64'd2);

        // no tail, accepted right after the abort
        fd_delay = 5;
        start(32'h3000_0000, 16'd870, 16'd0, 16'd2, 4'd0);
        run_until_end(200, "notail");
        repeat (3) step();
        check("notail_ncmd", 64'(hs_addr.size()), 64'd2);
        if (hs_addr.size() == 2) begin
            check("notail_addr1", 64'(hs_addr[1]), 64'h3000_0366);
            check("notail_len0", 64'(hs_len[0]), 64'd870);
            check("notail_len1", 64'(hs_len[1]), 64'd870);
            check("notail_last0", 64'(hs_last[0]), 64'd0);
            check("notail_last1", 64'(hs_last[1]), 64'd1);
        end
        check("notail_irq_cnt", 64'(irq_cnt), 64'd1);
        check("notail_fcnt", 64'(o_frame_cnt), 64'd2);

        // throttle with backpressure, then a soft reset mid-command
        fd_delay = 0;
        stall    = 3;
        start(32'h4000_0000, 16'd870, 16'd0, 16'd3, 4'd0);
        repeat (10) step();
        check("thr_ncmd", 64'(hs_addr.size()), 64'd2);
        check("thr_valid_low", 64'(o_cmd_valid), 64'd0);
        check("thr_busy", 64'(o_busy), 64'd1);
        if (hs_addr.size() > 0) check("thr_addr0", 64'(hs_addr[0]), 64'h4000_0000);
        ready_en     = 1'b0;
        i_frame_done = 1'b1;
        step();
        check("thr_release", 64'(o_cmd_valid), 64'd1);
        check("thr_fcnt", 64'(o_frame_cnt), 64'd1);
        check("thr_addr2", 64'(o_cmd_addr), 64'h4000_06CC);
        check("thr_len2", 64'(o_cmd_len), 64'd870);
        check("thr_last2", 64'(o_cmd_last), 64'd1);
        i_soft_rst = 1'b1;
        step();
        i_soft_rst = 1'b0;
        check("srst_valid", 64'(o_cmd_valid), 64'd0);
        check("srst_addr", 64'(o_cmd_addr), 64'd0);
        check("srst_len", 64'(o_cmd_len), 64'd0);
        check("srst_last", 64'(o_cmd_last), 64'd0);
        check("srst_busy", 64'(o_busy), 64'd0);
        check("srst_fcnt", 64'(o_frame_cnt), 64'd0);
        ready_en = 1'b1;
        stall    = 0;

        // address wraps at the top of the space
        fd_delay = 5;
        start(32'hFFFF_FE00, 16'd870, 16'd0, 16'd2, 4'd0);
        run_until_end(200, "wrap");
        check("wrap_ncmd", 64'(hs_addr.size()), 64'd2);
        if (hs_addr.size() == 2) begin
            check("wrap_addr0", 64'(hs_addr[0]), 64'hFFFF_FE00);
            check("wrap_addr1", 64'(hs_addr[1]), 64'h0000_0166);
        end
        check("wrap_irq_cnt", 64'(irq_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
